// File: rtl/word_derotator_pkg.sv
// word_derotator_pkg: shared sizing helpers, FSM states and frame classes for the derotator.
package word_derotator_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int word_num(input int bus_size, input int word_size);
        return bus_size / word_size;
    endfunction

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1
    } state_e;

    typedef enum logic [1:0] {
        CL_IDLE = 2'd0,
        CL_GOOD = 2'd1,
        CL_BAD  = 2'd2
    } class_e;

endpackage

// File: rtl/word_derotator_rotate_right.sv
// word_rotate_right: combinational barrel derotator, out word i = in word (i+r) mod WORD_NUM.
module word_rotate_right
    import word_derotator_pkg::*;
#(
    parameter int BUS_SIZE  = 32,
    parameter int WORD_SIZE = 4,
    parameter int WORD_NUM  = word_num(BUS_SIZE, WORD_SIZE),
    parameter int LW        = clog2(WORD_NUM)
) (
    input  logic [BUS_SIZE-1:0] data_i,
    input  logic [LW-1:0]       r_i,
    output logic [BUS_SIZE-1:0] data_o
);
    // WORD_NUM is a power of two, so the index wraps naturally in LW bits.
    for (genvar g = 0; g < WORD_NUM; g++) begin : g_word
        logic [LW-1:0] idx;
        assign idx = r_i + LW'(g);
        assign data_o[g*WORD_SIZE +: WORD_SIZE] = data_i[idx*WORD_SIZE +: WORD_SIZE];
    end

endmodule

// File: rtl/word_derotator.sv
// word_derotator: two-stage receive derotator with frame integrity checks, lock FSM and error counter.
module word_derotator
    import word_derotator_pkg::*;
#(
    parameter int BUS_SIZE  = 32,
    parameter int WORD_SIZE = 4,
    parameter int WORD_NUM  = word_num(BUS_SIZE, WORD_SIZE),
    parameter int LOCK_GOOD = 2,
    parameter int LOSS_BAD  = 3,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUS_SIZE-1:0] data_in,
    input  logic [WORD_NUM-1:0] control_in,
    input  logic                error_in,
    output logic [BUS_SIZE-1:0] data_out,
    output logic                valid_out,
    output logic                error_out,
    output logic                locked,
    output logic [CNT_W-1:0]    err_count
);
    localparam int LW    = clog2(WORD_NUM);
    localparam int RUN_W = clog2(max2(LOCK_GOOD, LOSS_BAD) + 1);

    logic [BUS_SIZE-1:0] data_q;
    logic [WORD_NUM-1:0] ctrl_q;
    logic                err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            ctrl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_in;
            ctrl_q <= control_in;
            err_q  <= error_in;
        end
    end

    logic [LW-1:0]       r;
    logic                one_hot;
    logic [BUS_SIZE-1:0] derot;
    class_e              cls;

    // OR-encode: exact for one-hot inputs, and non-one-hot frames are rejected anyway.
    always_comb begin
        r = '0;
        for (int i = 0; i < WORD_NUM; i++) r = ctrl_q[i] ? (r | LW'(i)) : r;
    end

    assign one_hot = (ctrl_q != '0) && ((ctrl_q & (ctrl_q - 1'b1)) == '0);

    word_rotate_right #(
        .BUS_SIZE (BUS_SIZE),
        .WORD_SIZE(WORD_SIZE),
        .WORD_NUM (WORD_NUM),
        .LW       (LW)
    ) u_rot (
        .data_i(data_q),
        .r_i   (r),
        .data_o(derot)
    );

    always_comb begin
        cls = (ctrl_q == '0 && !err_q) ? CL_IDLE :
              (err_q || !one_hot || derot[BUS_SIZE-1 -: WORD_SIZE] != '1 || derot[LW-1:0] != r) ? CL_BAD :
              CL_GOOD;
    end

    logic [BUS_SIZE-1:0] data_out_q, data_out_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    state_e              state_q, state_d;
    logic [RUN_W-1:0]    good_q, good_d, good_inc;
    logic [RUN_W-1:0]    bad_q, bad_d, bad_inc;

    assign good_inc = good_q + 1'b1;
    assign bad_inc  = bad_q + 1'b1;

    always_comb begin
        data_out_d = (cls == CL_GOOD) ? derot : '0;
        valid_d    = (cls == CL_GOOD);
        error_d    = (cls == CL_BAD);
        cnt_d      = (cls == CL_BAD && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        case (state_q)
            ST_SEARCH: begin
                if (cls == CL_GOOD) begin
                    state_d = (good_inc == RUN_W'(LOCK_GOOD)) ? ST_LOCKED : ST_SEARCH;
                    good_d  = (good_inc == RUN_W'(LOCK_GOOD)) ? '0 : good_inc;
                    bad_d   = '0;
                end else if (cls == CL_BAD) begin
                    good_d = '0;
                end
            end
            ST_LOCKED: begin
                if (cls == CL_BAD) begin
                    state_d = (bad_inc == RUN_W'(LOSS_BAD)) ? ST_SEARCH : ST_LOCKED;
                    bad_d   = (bad_inc == RUN_W'(LOSS_BAD)) ? '0 : bad_inc;
                    good_d  = '0;
                end else if (cls == CL_GOOD) begin
                    bad_d = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
                bad_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_SEARCH;
            good_q     <= '0;
            bad_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign error_out = error_q;
    assign locked    = (state_q == ST_LOCKED);
    assign err_count = cnt_q;

endmodule

// File: tb/tb_word_derotator.sv
// tb_word_derotator: randomized scoreboard bench for word_derotator against a word-array reference model.
module tb_word_derotator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  control_in = '0;
    logic        error_in = 1'b0;
    logic [31:0] data_out;
    logic        valid_out, error_out, locked;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    word_derotator dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .control_in(control_in),
        .error_in  (error_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .error_out (error_out),
        .locked    (locked),
        .err_count (err_count)
    );

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        v;
        logic        e;
        logic        l;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   m_locked = 0;
    int   m_good = 0, m_bad = 0, m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Rotator: in word i -> out word (i+r)%8; inverse: out word i = in word (i+r)%8.
    function automatic logic [31:0] rotate(input logic [31:0] w, input int r, input bit inverse);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            if (inverse) o[i*4 +: 4] = w[((i + r) % 8)*4 +: 4];
            else         o[((i + r) % 8)*4 +: 4] = w[i*4 +: 4];
        end
        return o;
    endfunction

    function automatic logic [31:0] frame_with_tail(input int r, input int tail);
        logic [31:0] o;
        o = $urandom;
        o[31:28] = 4'hF;
        o[2:0] = 3'(tail);
        return rotate(o, r, 0);
    endfunction

    task automatic apply(input logic rn, input logic [31:0] d, input logic [7:0] c, input logic e);
        exp_t        x;
        int          r;
        bit          bad;
        logic [31:0] o;
        @(negedge clk);
        reset = rn;
        data_in = d;
        control_in = c;
        error_in = e;
        if (!rn) begin
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
            m_locked = 0; m_good = 0; m_bad = 0; m_cnt = 0;
            x = '{due: cyc + 1, d: '0, v: 1'b0, e: 1'b0, l: 1'b0, cnt: '0};
            sb.push_back(x);
            x.due = cyc + 2;
            sb.push_back(x);
        end else begin
            x = '{due: cyc + 2, d: '0, v: 1'b0, e: 1'b0, l: 1'b0, cnt: '0};
            if (c != 0 || e) begin
                r = 0;
                for (int i = 0; i < 8; i++) if (c[i]) r = i;
                bad = e || ($countones(c) != 1);
                o = rotate(d, r, 1);
                if (!bad) bad = (o[31:28] != 4'hF) || (o[2:0] != 3'(r));
                if (bad) begin
                    x.e = 1'b1;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    if (m_locked) begin
                        m_bad++;
                        if (m_bad == 3) begin m_locked = 0; m_bad = 0; m_good = 0; end
                    end else m_good = 0;
                end else begin
                    x.d = o;
                    x.v = 1'b1;
                    if (!m_locked) begin
                        m_good++;
                        if (m_good == 2) begin m_locked = 1; m_good = 0; m_bad = 0; end
                    end else m_bad = 0;
                end
            end
            x.l = m_locked;
            x.cnt = 8'(m_cnt);
            sb.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mx = sb.pop_front();
            vectors++;
            if (mx.due != cyc || data_out !== mx.d || valid_out !== mx.v || error_out !== mx.e ||
                locked !== mx.l || err_count !== mx.cnt) begin
                miscompares++;
                $display("FAIL cycle %0d (due %0d): got data=%h v=%b e=%b l=%b cnt=%0d, want data=%h v=%b e=%b l=%b cnt=%0d",
                         cyc, mx.due, data_out, valid_out, error_out, locked, err_count,
                         mx.d, mx.v, mx.e, mx.l, mx.cnt);
            end
        end
    end

    initial begin
        int k, r, s;
        logic [7:0] c;
        repeat (3) apply(0, '0, '0, 0);
        apply(1, '0, '0, 0);
        apply(1, 32'hF1234560, 8'h01, 0);
        apply(1, 32'hF1234560, 8'h01, 0);
        apply(1, 32'hCDEF3FAB, 8'h08, 0);
        apply(1, 32'hCDEF5FAB, 8'h08, 0);
        apply(1, 32'hF1234560, 8'h01, 0);
        apply(1, 32'hCDEF3FAB, 8'h0C, 0);
        apply(1, '0, '0, 0);
        apply(1, 32'hCDEF3FAB, 8'h0C, 0);
        apply(1, 32'hCDEF3FAB, 8'h0C, 0);
        apply(1, '0, '0, 0);
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            r = $urandom_range(0, 7);
            s = $urandom_range(1, 7);
            c = 8'(1 << r);
            case (k)
                0, 1, 2, 3, 4: apply(1, frame_with_tail(r, r), c, 0);
                5: apply(1, $urandom, '0, 0);
                6: apply(1, frame_with_tail(r, r), c, 1);
                7: apply(1, frame_with_tail(r, r), c | 8'(1 << ((r + s) % 8)), 0);
                8: apply(1, frame_with_tail(r, r + s), c, 0);
                default: apply(1, $urandom, 8'($urandom), 1'($urandom));
            endcase
        end
        for (int n = 0; n < 260; n++) apply(1, $urandom, 8'(1 << $urandom_range(0, 7)), 1);
        apply(1, frame_with_tail(2, 2), 8'h04, 0);
        apply(1, frame_with_tail(5, 5), 8'h20, 0);
        apply(0, frame_with_tail(1, 1), 8'h02, 0);
        apply(1, frame_with_tail(6, 6), 8'h40, 0);
        apply(0, frame_with_tail(3, 3), 8'h08, 0);
        apply(0, '0, '0, 1);
        apply(1, frame_with_tail(4, 4), 8'h10, 0);
        apply(1, frame_with_tail(7, 7), 8'h80, 0);
        apply(1, frame_with_tail(0, 0), 8'h01, 0);
        apply(1, '0, '0, 0);
        for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected outputs never observed, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/word_derotator.md
Name: word_derotator

Overview:
- Receive-side inverse of the word rotator.
- Takes a rotated frame plus its one-hot rotation indicator and restores the original word order.
- Checks frame integrity (head word all ones, tail consistent with rotation) and tracks link lock with a small FSM.
- Sits downstream of the rotator; the bench compares it against the synthesized netlist exactly as the rotator is compared.

Parameters:
- BUS_SIZE, 32: frame width in bits.
- WORD_SIZE, 4: word width in bits.
- WORD_NUM, BUS_SIZE/WORD_SIZE: words per frame. Must be a power of two.
- LOCK_GOOD, 2: consecutive GOOD frames required to enter LOCKED.
- LOSS_BAD, 3: consecutive BAD frames in LOCKED that drop lock.
- CNT_W, 8: width of the error counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- data_in  in  BUS_SIZE  rotated frame; word i = bits [i*WORD_SIZE +: WORD_SIZE].
- control_in  in  WORD_NUM  one-hot rotation amount r (bit r set).
- error_in  in  1  upstream flags the frame invalid.
- data_out  out  BUS_SIZE  derotated frame.
- valid_out  out  1  data_out holds a GOOD frame.
- error_out  out  1  frame classified BAD.
- locked  out  1  FSM in LOCKED.
- err_count  out  CNT_W  saturating count of BAD frames.

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-low. While reset==0, all registers and outputs are 0: data_out=0, valid_out=0, error_out=0, locked=0, err_count=0, FSM=SEARCH, run counters=0.
- A reset asserted mid-operation discards both pipeline stages on the next edge.
- Pipeline:
  - Stage 1 registers data_in, control_in, error_in every cycle while reset==1.
  - Stage 2 derotates, classifies, and registers all outputs.
  - Latency: a frame sampled at edge n appears on the outputs after edge n+2. Throughput is one frame per cycle; there is no backpressure.
- Rotation convention: the rotator maps input word i to output word (i+r) mod WORD_NUM. Derotation is out word i = in word (i+r) mod WORD_NUM.
- Frame classification, first match wins:
  - IDLE: control_in==0 and error_in==0.
  - BAD: error_in==1, or control_in not one-hot (including 0 with error_in=1, or multiple bits set), or derotated head word (word WORD_NUM-1) is not all ones, or derotated tail word (word 0) mod WORD_NUM differs from r.
  - GOOD: otherwise.
- Outputs per class:
  - GOOD: data_out = derotated frame, valid_out=1, error_out=0.
  - BAD: data_out=0, valid_out=0, error_out=1, err_count += 1, saturating at all ones.
  - IDLE: data_out=0, valid_out=0, error_out=0. IDLE frames neither advance nor clear the run counters.
- FSM, registered; locked updates on the same edge as the outputs of the causing frame:
  - SEARCH: GOOD increments good_run; BAD clears good_run. When good_run reaches LOCK_GOOD, go to LOCKED and clear the runs.
  - LOCKED: BAD increments bad_run; GOOD clears bad_run. When bad_run reaches LOSS_BAD, go to SEARCH, set locked=0 and clear the runs.
  - A third state is not used; unreachable encodings return to SEARCH.
- Width rules:
  - Run counters are clog2(max(LOCK_GOOD, LOSS_BAD)+1) bits.
  - r is derived from the one-hot vector by priority-free encode, valid only when one-hot.
  - The tail comparison uses the low clog2(WORD_NUM) bits of the tail word.

Decomposition:
- Shared package: WORD_NUM derivation, a clog2 function, FSM state constants (ST_SEARCH, ST_LOCKED), and frame-class constants (CL_IDLE, CL_GOOD, CL_BAD).
- One natural sub-module, word_rotate_right: a combinational barrel derotator (data, r) -> data. It is reused by the rotator's own golden model in the bench.
- The FSM, checks and counters stay in the top module.

Test Plan (BUS_SIZE=32, WORD_SIZE=4):
- Reset held 3 cycles, then release with idle input (all zeros) -> all outputs 0, err_count=0, locked=0.
- Zero rotation: data_in=0xF1234560, control_in=0x01 -> two cycles later data_out=0xF1234560, valid_out=1; a second such frame -> locked=1 on its output cycle.
- Rotation 3: data_in=0xCDEF3FAB, control_in=0x08 -> data_out=0xFABCDEF3, valid_out=1, error_out=0.
- Inconsistent tail: derotated frame 0xFABCDEF5 sent with control_in=0x08 -> error_out=1, data_out=0, err_count increments by 1.
- Lock loss: while locked, 3 frames with control_in=0x0C -> error_out=1 each, locked falls on the third; an interleaved IDLE frame does not reset bad_run.
- Saturation plus mid-run reset: 260 BAD frames -> err_count holds 0xFF; assert reset mid-stream -> outputs 0 on the next edge, and in-flight frames are never output.
